alu_cmd_sequencer: RTL

Synthesizable, parametrised command front-end for the TinyALU datapath. It accepts operation commands over a valid/ready stream and buffers them in a DEPTH-entry FIFO. It drives the ALU start/op/A/B/done handshake, including the no_op and rst_op special cases and a done-timeout. Results return on a one-entry valid/ready response port. It sits between the stimulus/CPU side and the ALU core, replacing bench-only task-based driving with cycle-accurate hardware.

---
 rtl/alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the TinyALU core: a DEPTH-entry command FIFO feeding a
// start/done handshake sequencer, with results returned on a one-entry response port.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [DATA_W-1:0]            cmd_a,
  input  logic [DATA_W-1:0]            cmd_b,
  output logic                         alu_start,
  output logic [2:0]                   alu_op,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic                         alu_reset_n,
  input  logic                         alu_done,
  input  logic [2*DATA_W-1:0]          alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [2*DATA_W-1:0]          rsp_result,
  output logic [2:0]                   rsp_op,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy,
  output logic [2:0]                   fsm_state
);

  // Handshakes (cmd and rsp): a beat transfers on a rising edge where valid and
  // ready are both high; a raised valid holds, payload unchanged, until that edge.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_WAIT = 3'd2,
    S_NOP  = 3'd3,
    S_RST  = 3'd4
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  state_t               state, state_d;
  logic                 start_d, arst_d;
  logic [2:0]           op_d;
  logic [DATA_W-1:0]    a_d, b_d;
  logic [TW-1:0]        wait_cnt, wait_d;
  logic                 rst_cnt, rst_cnt_d;
  logic                 rv_d, rerr_d;
  logic [2*DATA_W-1:0]  rres_d;
  logic [2:0]           rop_d;
  logic                 rsp_free, is_arith;

  // A response leaving this cycle frees the slot, so the next op can issue now.
  assign rsp_free = !rsp_valid || rsp_ready;
  assign is_arith = (head.op == OP_ADD) || (head.op == OP_AND) ||
                    (head.op == OP_XOR) || (head.op == OP_MUL);

  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    start_d   = alu_start;
    op_d      = alu_op;
    a_d       = alu_a;
    b_d       = alu_b;
    arst_d    = alu_reset_n;
    wait_d    = wait_cnt;
    rst_cnt_d = rst_cnt;
    rv_d      = rsp_valid && !rsp_ready;
    rres_d    = rsp_result;
    rop_d     = rsp_op;
    rerr_d    = rsp_err;
    case (state)
      S_INIT: begin
        arst_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (fifo_count != '0) begin
          if (head.op == OP_NOP) begin
            pop     = 1'b1;
            op_d    = OP_NOP;
            a_d     = head.a;
            b_d     = head.b;
            start_d = 1'b1;
            state_d = S_NOP;
          end else if (head.op == OP_RST) begin
            pop       = 1'b1;
            arst_d    = 1'b0;
            start_d   = 1'b0;
            rst_cnt_d = 1'b0;
            state_d   = S_RST;
          end else if (rsp_free) begin
            pop = 1'b1;
            if (is_arith) begin
              op_d    = head.op;
              a_d     = head.a;
              b_d     = head.b;
              start_d = 1'b1;
              wait_d  = '0;
              state_d = S_WAIT;
            end else begin
              rv_d   = 1'b1;
              rerr_d = 1'b1;
              rres_d = '0;
              rop_d  = head.op;
            end
          end
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          rres_d  = alu_result;
          rop_d   = alu_op;
          rerr_d  = 1'b0;
          rv_d    = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end else if (wait_cnt == TW'(TIMEOUT-1)) begin
          rres_d  = '0;
          rop_d   = alu_op;
          rerr_d  = 1'b1;
          rv_d    = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_cnt + TW'(1);
        end
      end
      S_NOP: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      S_RST: begin
        if (rst_cnt) begin
          arst_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_INIT;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_reset_n <= 1'b0;
      wait_cnt    <= '0;
      rst_cnt     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_d;
      alu_start   <= start_d;
      alu_op      <= op_d;
      alu_a       <= a_d;
      alu_b       <= b_d;
      alu_reset_n <= arst_d;
      wait_cnt    <= wait_d;
      rst_cnt     <= rst_cnt_d;
      rsp_valid   <= rv_d;
      rsp_result  <= rres_d;
      rsp_op      <= rop_d;
      rsp_err     <= rerr_d;
    end
  end

  assign busy      = ((state != S_IDLE) && (state != S_INIT)) || (fifo_count != '0);
  assign fsm_state = state;

endmodule
